// File: rtl/gray_counter_ctrl_if.sv
// gray_counter_ctrl_if
//   Bundles the control inputs and the count/status outputs of the Gray
//   counter run controller.
//   master : the controlling side (buttons/switches or a testbench) that
//            drives start/stop/step/dir/oneshot and reads the count.
//   slave  : the controller itself.
//   Signals:
//     start, stop, step   edge-triggered requests
//     dir                 count direction (0 = up, 1 = down)
//     oneshot             level, stop after one full wrap in RUN
//     bin, gray           registered count in binary and Gray code
//     tick, wrap          one-cycle strobes on each advance / wrap-around
//     busy                high while running
//     state               IDLE=00, RUN=01, PAUSE=10, DONE=11
interface gray_counter_ctrl_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic             stop;
  logic             step;
  logic             dir;
  logic             oneshot;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic             tick;
  logic             wrap;
  logic             busy;
  logic [1:0]       state;

  modport master (
    output start, stop, step, dir, oneshot,
    input  bin, gray, tick, wrap, busy, state
  );

  modport slave (
    input  start, stop, step, dir, oneshot,
    output bin, gray, tick, wrap, busy, state
  );
endinterface

// File: rtl/gray_counter_ctrl.sv
// gray_counter_ctrl
//   Run controller for a Gray-code counter. A clock-enable prescaler on the
//   single system clock advances the count once every DIV cycles while in
//   RUN; start/stop/step requests (rising-edge detected) move the controller
//   through IDLE/RUN/PAUSE/DONE. All outputs are registered.
//   Parameters:
//     DIV    clk cycles per advance in RUN (>= 1)
//     WIDTH  counter width in bits
//   Ports:
//     clk    system clock, rising edge
//     clr    asynchronous active-high reset
//     bus    gray_counter_ctrl_if.slave (controls in, count/status out)
//   Build option:
//     GC_DIR_EN  when defined, bus.dir selects down-counting (wrap on 0->max);
//                otherwise the counter is up-only and dir is ignored.
module gray_counter_ctrl #(
  parameter int DIV   = 100_000_000,
  parameter int WIDTH = 3
) (
  input logic                clk,
  input logic                clr,
  gray_counter_ctrl_if.slave bus
);

  localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t           state_reg;
  logic [PW-1:0]    presc_reg;
  logic [WIDTH-1:0] bin_reg;
  logic [WIDTH-1:0] gray_reg;
  logic             tick_reg;
  logic             wrap_reg;
  logic             busy_reg;
  logic             start_q_reg;
  logic             stop_q_reg;
  logic             step_q_reg;

  logic             start_ev;
  logic             stop_ev;
  logic             step_ev;
  logic             terminal;
  logic             count_down;
  logic [WIDTH-1:0] adv_bin;
  logic [WIDTH-1:0] adv_gray;
  logic             adv_wrap;

  assign start_ev = bus.start & ~start_q_reg;
  assign stop_ev  = bus.stop  & ~stop_q_reg;
  assign step_ev  = bus.step  & ~step_q_reg;
  assign terminal = (presc_reg == PRESC_LAST);

`ifdef GC_DIR_EN
  assign count_down = bus.dir;
`else
  // Port kept for pin compatibility; up-only build never looks at it.
  logic dir_unused;
  assign dir_unused = bus.dir;
  assign count_down = 1'b0;
`endif

  // Candidate next count for any advance this cycle (RUN terminal or step).
  always_comb begin
    adv_bin  = count_down ? (bin_reg - WIDTH'(1)) : (bin_reg + WIDTH'(1));
    adv_wrap = count_down ? (bin_reg == '0) : (bin_reg == '1);
    adv_gray = adv_bin ^ (adv_bin >> 1);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg   <= S_IDLE;
      presc_reg   <= '0;
      bin_reg     <= '0;
      gray_reg    <= '0;
      tick_reg    <= 1'b0;
      wrap_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      start_q_reg <= 1'b0;
      stop_q_reg  <= 1'b0;
      step_q_reg  <= 1'b0;
    end else begin
      start_q_reg <= bus.start;
      stop_q_reg  <= bus.stop;
      step_q_reg  <= bus.step;
      tick_reg    <= 1'b0;
      wrap_reg    <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start_ev) begin
            state_reg <= S_RUN;
            busy_reg  <= 1'b1;
            presc_reg <= '0;
          end else if (step_ev) begin
            bin_reg  <= adv_bin;
            gray_reg <= adv_gray;
            tick_reg <= 1'b1;
            wrap_reg <= adv_wrap;
          end
        end
        S_RUN: begin
          if (terminal) begin
            // Terminal count always advances, even if stop arrives now.
            presc_reg <= '0;
            tick_reg  <= 1'b1;
            wrap_reg  <= adv_wrap;
            if (stop_ev) begin
              state_reg <= S_PAUSE;
              busy_reg  <= 1'b0;
              bin_reg   <= adv_bin;
              gray_reg  <= adv_gray;
            end else if (adv_wrap && bus.oneshot) begin
              // DONE parks the count at zero regardless of direction.
              state_reg <= S_DONE;
              busy_reg  <= 1'b0;
              bin_reg   <= '0;
              gray_reg  <= '0;
            end else begin
              bin_reg  <= adv_bin;
              gray_reg <= adv_gray;
            end
          end else if (stop_ev) begin
            // Prescaler is held so a later resume keeps the phase.
            state_reg <= S_PAUSE;
            busy_reg  <= 1'b0;
          end else begin
            presc_reg <= presc_reg + PW'(1);
          end
        end
        S_PAUSE: begin
          if (start_ev) begin
            state_reg <= S_RUN;
            busy_reg  <= 1'b1;
          end else if (step_ev) begin
            bin_reg  <= adv_bin;
            gray_reg <= adv_gray;
            tick_reg <= 1'b1;
            wrap_reg <= adv_wrap;
          end
        end
        S_DONE: begin
          if (start_ev) begin
            state_reg <= S_RUN;
            busy_reg  <= 1'b1;
            presc_reg <= '0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.bin   = bin_reg;
  assign bus.gray  = gray_reg;
  assign bus.tick  = tick_reg;
  assign bus.wrap  = wrap_reg;
  assign bus.busy  = busy_reg;
  assign bus.state = state_reg;

endmodule

// File: tb/tb_gray_counter_ctrl.sv
module tb_gray_counter_ctrl;

  localparam int DIV   = 4;
  localparam int WIDTH = 3;
  localparam int MOD   = 1 << WIDTH;
`ifdef GC_DIR_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  gray_counter_ctrl_if #(.WIDTH(WIDTH)) bus ();

  gray_counter_ctrl #(.DIV(DIV), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: state as spec code (0 idle,1 run,2 pause,3 done),
  // count as an integer, phase = cycles spent toward the next advance.
  int m_state, m_count, m_phase;
  bit m_tick, m_wrap;
  bit m_ps, m_pt, m_pp;

  int tick_seen = 0;
  int wrap_seen = 0;
  int gray_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int to_gray(input int v);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    m_state = 0; m_count = 0; m_phase = 0;
    m_tick = 0; m_wrap = 0;
    m_ps = 0; m_pt = 0; m_pp = 0;
  endtask

  task automatic model_advance(input bit d);
    if (DIR_EN && d) begin
      m_wrap  = (m_count == 0);
      m_count = (m_count + MOD - 1) % MOD;
    end else begin
      m_count = (m_count + 1) % MOD;
      m_wrap  = (m_count == 0);
    end
    m_tick = 1;
  endtask

  task automatic model_edge(input bit s, input bit t, input bit p, input bit d, input bit o);
    bit sev, tev, pev;
    sev = s && !m_ps; tev = t && !m_pt; pev = p && !m_pp;
    m_ps = s; m_pt = t; m_pp = p;
    m_tick = 0; m_wrap = 0;
    case (m_state)
      0: if (sev) begin m_state = 1; m_phase = 0; end
         else if (pev) model_advance(d);
      1: if (m_phase == DIV - 1) begin
           m_phase = 0;
           model_advance(d);
           if (tev) m_state = 2;
           else if (m_wrap && o) begin m_state = 3; m_count = 0; end
         end else if (tev) m_state = 2;
         else m_phase++;
      2: if (sev) m_state = 1;
         else if (pev) model_advance(d);
      default: if (sev) begin m_state = 1; m_phase = 0; end
    endcase
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, ".bin"},   int'(bus.bin),   m_count);
    check({ctx, ".gray"},  int'(bus.gray),  to_gray(m_count));
    check({ctx, ".tick"},  int'(bus.tick),  int'(m_tick));
    check({ctx, ".wrap"},  int'(bus.wrap),  int'(m_wrap));
    check({ctx, ".busy"},  int'(bus.busy),  (m_state == 1) ? 1 : 0);
    check({ctx, ".state"}, int'(bus.state), m_state);
  endtask

  // One clock: drive at the falling edge, model on the rising edge,
  // sample at the next falling edge.
  task automatic do_cycle(input bit s, input bit t, input bit p, input bit d, input bit o);
    bus.start = s; bus.stop = t; bus.step = p; bus.dir = d; bus.oneshot = o;
    @(posedge clk);
    model_edge(s, t, p, d, o);
    @(negedge clk);
    if (bus.tick) begin
      tick_seen++;
      gray_q.push_back(int'(bus.gray));
    end
    if (bus.wrap) wrap_seen++;
    compare_all("cyc");
    if (bus.tick || s || t || p)
      $display("t=%0t in s/t/p/d/o=%0b%0b%0b%0b%0b state=%0d bin=%0d gray=%b tick=%0b wrap=%0b",
               $time, s, t, p, d, o, bus.state, bus.bin, bus.gray, bus.tick, bus.wrap);
  endtask

  task automatic idle(input int n, input bit o);
    repeat (n) do_cycle(0, 0, 0, 0, o);
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic async_reset();
    bus.start = 0; bus.stop = 0; bus.step = 0;
    #2 clr = 1'b1;
    #1 model_reset();
    compare_all("async_rst");
    $display("t=%0t async reset state=%0d bin=%0d", $time, bus.state, bus.bin);
    #1 clr = 1'b0;
  endtask

  initial begin
    int t0, w0, n, k, entries, prev_state, bin0;
    int exp_seq[8] = '{1, 3, 2, 6, 7, 5, 4, 0};
    bit rs, rt, rp, rd, ro;

    clr = 1'b1;
    bus.start = 0; bus.stop = 0; bus.step = 0; bus.dir = 0; bus.oneshot = 0;
    model_reset();
    @(negedge clk);
    compare_all("reset");
    #2 clr = 1'b0;

    // Free run at DIV=4: eight advances in 32 cycles, one wrap.
    t0 = tick_seen; w0 = wrap_seen; gray_q.delete();
    do_cycle(1, 0, 0, 0, 0);
    idle(32, 0);
    check("seq_ticks", tick_seen - t0, 8);
    check("seq_wraps", wrap_seen - w0, 1);
    check("seq_len", gray_q.size(), 8);
    for (int i = 0; i < 8 && i < gray_q.size(); i++)
      check($sformatf("seq_gray%0d", i), gray_q[i], exp_seq[i]);

    // Stop with prescaler at 2, idle, resume: next tick after 2 edges.
    n = 0;
    while (m_phase != 2 && n < 10) begin idle(1, 0); n++; end
    do_cycle(0, 1, 0, 0, 0);
    bin0 = m_count;
    idle(10, 0);
    check("pause_state", int'(bus.state), 2);
    check("pause_bin_frozen", int'(bus.bin), bin0);
    do_cycle(1, 0, 0, 0, 0);
    k = 0;
    do begin idle(1, 0); k++; end while (!bus.tick && k < 10);
    check("resume_latency", k, 2);

    // Reach bin 3 mid-phase, pause, then single step.
    n = 0;
    while (!(m_count == 3 && m_phase != DIV - 1) && n < 80) begin idle(1, 0); n++; end
    do_cycle(0, 1, 0, 0, 0);
    check("pause3_bin", int'(bus.bin), 3);
    t0 = tick_seen;
    do_cycle(0, 0, 1, 0, 0);
    check("step_bin", int'(bus.bin), 4);
    check("step_gray", int'(bus.gray), 3'b110);
    idle(3, 0);
    check("step_ticks", tick_seen - t0, 1);

    // Start and stop rising together in RUN: stop wins.
    do_cycle(1, 0, 0, 0, 0);
    idle(1, 0);
    do_cycle(1, 1, 0, 0, 0);
    check("prio_state", int'(bus.state), 2);

    // Reset mid-RUN at bin 5, then hold start high.
    do_cycle(0, 0, 0, 0, 0);
    do_cycle(1, 0, 0, 0, 0);
    n = 0;
    while (m_count != 5 && n < 80) begin idle(1, 0); n++; end
    check("reach_bin5", int'(bus.bin), 5);
    async_reset();
    check("rst_bin", int'(bus.bin), 0);
    check("rst_state", int'(bus.state), 0);
    entries = 0;
    for (int i = 0; i < 20; i++) begin
      prev_state = int'(bus.state);
      do_cycle(1, 0, 0, 0, 0);
      if (bus.state == 2'b01 && prev_state != 1) entries++;
    end
    check("run_entries", entries, 1);

    // Oneshot: DONE after the 8th advance, then silent.
    async_reset();
    t0 = tick_seen;
    do_cycle(1, 0, 0, 0, 1);
    idle(32, 1);
    check("os_ticks", tick_seen - t0, 8);
    check("os_state", int'(bus.state), 3);
    check("os_bin", int'(bus.bin), 0);
    check("os_busy", int'(bus.busy), 0);
    t0 = tick_seen;
    idle(20, 1);
    check("os_silent", tick_seen - t0, 0);

    // Step down from zero.
    async_reset();
    do_cycle(0, 0, 1, 1, 0);
`ifdef GC_DIR_EN
    check("dir_bin", int'(bus.bin), 7);
    check("dir_gray", int'(bus.gray), 3'b100);
    check("dir_wrap", int'(bus.wrap), 1);
`else
    check("dir_bin", int'(bus.bin), 1);
    check("dir_gray", int'(bus.gray), 3'b001);
    check("dir_wrap", int'(bus.wrap), 0);
`endif

    // Randomised soak against the model.
    rs = 0; rt = 0; rp = 0; rd = 0; ro = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) async_reset();
      if ($urandom_range(0, 5) == 0) rs = ~rs;
      if ($urandom_range(0, 11) == 0) rt = ~rt;
      if ($urandom_range(0, 7) == 0) rp = ~rp;
      if ($urandom_range(0, 15) == 0) rd = ~rd;
      if ($urandom_range(0, 63) == 0) ro = ~ro;
      do_cycle(rs, rt, rp, rd, ro);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
